// File: rtl/control_secuencia_pc.sv
// Instruction sequencer for a load/increment program counter.
// Decodes the word at pc_cur each cycle and decides whether the counter increments,
// loads a target, or holds. The counter has no enable input, so a hold is a reload
// of pc_cur. Supports JMP, JZ, CALL/RET with a small return stack, WAIT n and HALT.
module control_secuencia_pc #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        instr,
    input  logic              zero_flag,
    input  logic [ADDR_W-1:0] pc_cur,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_in,
    output logic              exec,
    output logic              busy,
    output logic              halted,
    output logic [1:0]        err
);

    // sp counts 0..STACK_DEPTH, so it needs one more code than the entry index
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_WAIT = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    localparam logic [1:0] ERR_OVF = 2'b01;
    localparam logic [1:0] ERR_UNF = 2'b10;

    typedef enum logic [1:0] {StIdle, StRun, StWait, StHalt} state_e;

    state_e            state;
    logic [SP_W-1:0]   sp;
    logic [4:0]        wcnt;
    logic [ADDR_W-1:0] stack_mem [2**IDX_W];

    logic [2:0]        opcode;
    logic [4:0]        operand;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] pop_addr;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic              stack_full;
    logic              stack_empty;

    assign opcode      = instr[7:5];
    assign operand     = instr[4:0];
    assign target      = ADDR_W'(operand);
    // CALL at the top address pushes 0: plain modular wrap, no error
    assign ret_addr    = pc_cur + ADDR_W'(1);
    assign push_idx    = IDX_W'(sp);
    assign pop_idx     = IDX_W'(sp - SP_W'(1));
    assign pop_addr    = stack_mem[pop_idx];
    assign stack_full  = (sp >= SP_FULL);
    assign stack_empty = (sp == '0);

    // Counter control and status flags, decoded from state and the current word
    always_comb begin
        pc_load = 1'b1;
        pc_in   = pc_cur;
        exec    = 1'b0;
        busy    = 1'b0;
        halted  = 1'b0;
        unique case (state)
            StIdle: begin
                pc_in = '0;
            end
            StRun: begin
                exec = 1'b1;
                busy = 1'b1;
                case (opcode)
                    OP_JMP: pc_in = target;
                    OP_JZ: begin
                        if (zero_flag) pc_in = target;
                        else           pc_load = 1'b0;
                    end
                    OP_CALL: begin
                        if (!stack_full) pc_in = target;
                    end
                    OP_RET: begin
                        if (!stack_empty) pc_in = pop_addr;
                    end
                    OP_WAIT: begin
                        if (operand == 5'd0) pc_load = 1'b0;
                    end
                    OP_HALT: pc_load = 1'b1;
                    // NOP and the reserved opcode both just advance
                    default: pc_load = 1'b0;
                endcase
            end
            StWait: begin
                busy = 1'b1;
                if (wcnt == 5'd1) pc_load = 1'b0;
            end
            StHalt: begin
                halted = 1'b1;
                if (start) pc_in = '0;
            end
        endcase
    end

    // Sequencer state, return stack, wait counter and sticky error
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= StIdle;
            sp    <= '0;
            wcnt  <= '0;
            err   <= 2'b00;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state <= StRun;
                        sp    <= '0;
                        err   <= 2'b00;
                    end
                end
                StRun: begin
                    case (opcode)
                        OP_CALL: begin
                            if (!stack_full) begin
                                stack_mem[push_idx] <= ret_addr;
                                sp                  <= sp + SP_W'(1);
                            end else begin
                                err   <= ERR_OVF;
                                state <= StHalt;
                            end
                        end
                        OP_RET: begin
                            if (!stack_empty) begin
                                sp <= sp - SP_W'(1);
                            end else begin
                                err   <= ERR_UNF;
                                state <= StHalt;
                            end
                        end
                        OP_WAIT: begin
                            if (operand != 5'd0) begin
                                wcnt  <= operand;
                                state <= StWait;
                            end
                        end
                        OP_HALT: state <= StHalt;
                        default: ;
                    endcase
                end
                StWait: begin
                    if (wcnt == 5'd1) state <= StRun;
                    else              wcnt  <= wcnt - 5'd1;
                end
                StHalt: begin
                    if (start) begin
                        state <= StRun;
                        sp    <= '0;
                        err   <= 2'b00;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_secuencia_pc.sv
// Bench for control_secuencia_pc: vector table, directed multi-cycle sequences and a
// randomized run against an instruction-level reference model.
module tb_control_secuencia_pc;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 4;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_WAIT = 2;
    localparam int M_HALT = 3;

    logic              CLK = 1'b0;
    logic              rst;
    logic              start;
    logic              zero_flag;
    logic [7:0]        instr;
    logic [ADDR_W-1:0] pc_cur;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_in;
    logic              exec;
    logic              busy;
    logic              halted;
    logic [1:0]        err;

    logic [7:0] rom [32];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] ins;
        logic       zf;
        logic [4:0] exp_pc;
        logic       exp_halted;
        logic [1:0] exp_err;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [12];
    logic [4:0] seq_a [4];
    logic [4:0] seq_b [5];

    // Reference model state
    int         m_mode;
    logic [4:0] m_pc;
    logic [4:0] m_stack [$];
    int         m_wleft;
    logic [1:0] m_err;

    control_secuencia_pc #(
        .ADDR_W     (ADDR_W),
        .STACK_DEPTH(DEPTH)
    ) dut (
        .CLK      (CLK),
        .rst      (rst),
        .start    (start),
        .instr    (instr),
        .zero_flag(zero_flag),
        .pc_cur   (pc_cur),
        .pc_load  (pc_load),
        .pc_in    (pc_in),
        .exec     (exec),
        .busy     (busy),
        .halted   (halted),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    assign instr = rom[pc_cur];

    // Program counter: load + increment, reset shared with the sequencer
    always @(posedge CLK) begin
        if (rst)          pc_cur <= '0;
        else if (pc_load) pc_cur <= pc_in;
        else              pc_cur <= pc_cur + 5'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_pc(input logic [4:0] a, input int maxc);
        int n;
        n = 0;
        while (pc_cur !== a && n < maxc) begin
            tick();
            n++;
        end
        chk("reach_pc", pc_cur, a);
    endtask

    // Instruction-level semantics for one clock, using the current inputs
    task automatic model_step();
        logic [7:0] w;
        logic [2:0] op;
        logic [4:0] n;
        logic [4:0] nxt;
        w   = rom[m_pc];
        op  = w[7:5];
        n   = w[4:0];
        nxt = m_pc + 5'd1;
        if (rst) begin
            m_mode = M_IDLE;
            m_stack.delete();
            m_err  = 2'b00;
            m_pc   = 5'd0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                m_pc = 5'd0;
                if (start) begin
                    m_mode = M_RUN;
                    m_err  = 2'b00;
                    m_stack.delete();
                end
            end
            M_RUN: begin
                case (op)
                    3'd1: m_pc = n;
                    3'd2: m_pc = zero_flag ? n : nxt;
                    3'd3: begin
                        if (m_stack.size() < DEPTH) begin
                            m_stack.push_back(nxt);
                            m_pc = n;
                        end else begin
                            m_err  = 2'b01;
                            m_mode = M_HALT;
                        end
                    end
                    3'd4: begin
                        if (m_stack.size() > 0) begin
                            m_pc = m_stack.pop_back();
                        end else begin
                            m_err  = 2'b10;
                            m_mode = M_HALT;
                        end
                    end
                    3'd5: begin
                        if (n == 5'd0) begin
                            m_pc = nxt;
                        end else begin
                            m_wleft = int'(n);
                            m_mode  = M_WAIT;
                        end
                    end
                    3'd6: m_mode = M_HALT;
                    default: m_pc = nxt;
                endcase
            end
            M_WAIT: begin
                m_wleft--;
                if (m_wleft == 0) begin
                    m_pc   = nxt;
                    m_mode = M_RUN;
                end
            end
            default: begin
                if (start) begin
                    m_pc   = 5'd0;
                    m_err  = 2'b00;
                    m_mode = M_RUN;
                    m_stack.delete();
                end
            end
        endcase
    endtask

    task automatic model_check();
        chk("rnd_pc", pc_cur, m_pc);
        chk("rnd_exec", exec, m_mode == M_RUN);
        chk("rnd_busy", busy, m_mode == M_RUN || m_mode == M_WAIT);
        chk("rnd_halted", halted, m_mode == M_HALT);
        chk("rnd_err", err, m_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{5'd7,  8'h00, 1'b0, 5'd8,  1'b0, 2'd0, 1'b1};
        vecs[1]  = '{5'd7,  8'hE5, 1'b0, 5'd8,  1'b0, 2'd0, 1'b1};
        vecs[2]  = '{5'd6,  8'h34, 1'b0, 5'd20, 1'b0, 2'd0, 1'b1};
        vecs[3]  = '{5'd3,  8'h49, 1'b0, 5'd4,  1'b0, 2'd0, 1'b1};
        vecs[4]  = '{5'd3,  8'h49, 1'b1, 5'd9,  1'b0, 2'd0, 1'b1};
        vecs[5]  = '{5'd2,  8'h6A, 1'b0, 5'd10, 1'b0, 2'd0, 1'b1};
        vecs[6]  = '{5'd0,  8'h80, 1'b0, 5'd0,  1'b1, 2'd2, 1'b0};
        vecs[7]  = '{5'd4,  8'hA0, 1'b0, 5'd5,  1'b0, 2'd0, 1'b1};
        vecs[8]  = '{5'd4,  8'hA3, 1'b0, 5'd4,  1'b0, 2'd0, 1'b1};
        vecs[9]  = '{5'd5,  8'hC0, 1'b0, 5'd5,  1'b1, 2'd0, 1'b0};
        vecs[10] = '{5'd31, 8'h00, 1'b0, 5'd0,  1'b0, 2'd0, 1'b1};
        vecs[11] = '{5'd31, 8'h6C, 1'b0, 5'd12, 1'b0, 2'd0, 1'b1};
        seq_a = '{5'd0, 5'd1, 5'd2, 5'd5};
        seq_b = '{5'd0, 5'd1, 5'd2, 5'd10, 5'd3};

        rst       = 1'b0;
        start     = 1'b0;
        zero_flag = 1'b0;
        clear_rom();

        // Reset state
        do_reset();
        chk("rst_pc_load", pc_load, 1);
        chk("rst_pc_in", pc_in, 0);
        chk("rst_exec", exec, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        chk("rst_pc", pc_cur, 0);

        // NOP, NOP, JMP 5, HALT; then hold at 5
        rom[2] = 8'h25;
        rom[5] = 8'hC0;
        do_start();
        for (int k = 0; k < 4; k++) begin
            chk("seqA_pc", pc_cur, seq_a[k]);
            chk("seqA_exec", exec, 1);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            chk("seqA_hold_pc", pc_cur, 5);
            chk("seqA_halted", halted, 1);
            tick();
        end

        // CALL 10 / RET returns to 3; RET at 3 then proves the stack emptied
        clear_rom();
        rom[2]  = 8'h6A;
        rom[10] = 8'h80;
        rom[3]  = 8'h80;
        do_reset();
        do_start();
        for (int k = 0; k < 5; k++) begin
            chk("seqB_pc", pc_cur, seq_b[k]);
            tick();
        end
        chk("seqB_pc_held", pc_cur, 3);
        chk("seqB_err", err, 2);
        chk("seqB_halted", halted, 1);

        // Five nested CALLs overflow a four-entry stack
        clear_rom();
        for (int k = 0; k < 5; k++) rom[k] = 8'h60 | 8'(k + 1);
        do_reset();
        do_start();
        for (int k = 0; k < 5; k++) begin
            chk("seqC_pc", pc_cur, k);
            tick();
        end
        chk("seqC_pc_held", pc_cur, 4);
        chk("seqC_err", err, 1);
        chk("seqC_halted", halted, 1);
        tick();
        chk("seqC_pc_still", pc_cur, 4);

        // RET on empty stack, then restart from HALT
        clear_rom();
        rom[0] = 8'h80;
        do_reset();
        do_start();
        chk("seqD_exec", exec, 1);
        tick();
        chk("seqD_err", err, 2);
        chk("seqD_halted", halted, 1);
        chk("seqD_pc", pc_cur, 0);
        start = 1'b1;
        #1;
        chk("seqD_restart_load", pc_load, 1);
        chk("seqD_restart_in", pc_in, 0);
        tick();
        start = 1'b0;
        chk("seqD_err_clr", err, 0);
        chk("seqD_pc0", pc_cur, 0);
        chk("seqD_busy", busy, 1);

        // WAIT 3 at 4 occupies four cycles
        clear_rom();
        rom[0] = 8'h24;
        rom[4] = 8'hA3;
        do_reset();
        do_start();
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("seqE_pc", pc_cur, 4);
            chk("seqE_exec", exec, (k == 0) ? 1 : 0);
            chk("seqE_busy", busy, 1);
            tick();
        end
        chk("seqE_next_pc", pc_cur, 5);
        chk("seqE_next_exec", exec, 1);

        // rst while waiting with wcnt=2 and one stack entry
        clear_rom();
        rom[0] = 8'h64;
        rom[4] = 8'hA3;
        do_reset();
        do_start();
        tick();
        tick();
        tick();
        chk("seqF_in_wait", busy & ~exec, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("seqF_pc_load", pc_load, 1);
        chk("seqF_pc_in", pc_in, 0);
        chk("seqF_busy", busy, 0);
        chk("seqF_exec", exec, 0);
        chk("seqF_halted", halted, 0);
        chk("seqF_err", err, 0);
        chk("seqF_pc", pc_cur, 0);

        // Single-instruction vector table
        for (int i = 0; i < 12; i++) begin
            clear_rom();
            rom[vecs[i].addr] = vecs[i].ins;
            if (vecs[i].addr != 5'd0) rom[0] = {3'b001, vecs[i].addr};
            zero_flag = vecs[i].zf;
            do_reset();
            do_start();
            wait_pc(vecs[i].addr, 8);
            chk($sformatf("vec%0d_exec", i), exec, 1);
            tick();
            chk($sformatf("vec%0d_pc", i), pc_cur, vecs[i].exp_pc);
            chk($sformatf("vec%0d_halted", i), halted, vecs[i].exp_halted);
            chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
        end
        zero_flag = 1'b0;

        // Random programs and inputs against the reference model
        for (int ep = 0; ep < 4; ep++) begin
            for (int a = 0; a < 32; a++) begin
                logic [2:0] op;
                logic [4:0] n;
                op = 3'($urandom_range(0, 7));
                n  = 5'($urandom_range(0, 31));
                if (op == 3'b101) n = 5'($urandom_range(0, 4));
                rom[a] = {op, n};
            end
            rst   = 1'b1;
            start = 1'b0;
            model_step();
            tick();
            rst = 1'b0;
            for (int c = 0; c < 400; c++) begin
                rst       = ($urandom_range(0, 99) == 0);
                start     = ($urandom_range(0, 7) == 0);
                zero_flag = 1'($urandom_range(0, 1));
                #1;
                model_check();
                model_step();
                tick();
            end
            rst   = 1'b0;
            start = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
